// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : 640x480@60 raster timing constants, derived totals and sync-window
//           bounds, the horizontal/vertical phase encoding shared by the VGA
//           timing controller, and a small width-conversion helper.
// Ports   : none (package)
// ----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  localparam int unsigned DIV_DEF      = 2;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam bit          SYNC_POL_DEF = 1'b0;

  localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  // Truncate an elaboration-time count to the raster counter width.
  function automatic logic [CNT_W-1:0] cnt_c(input int unsigned v);
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_pix_tick_gen.sv
// ----------------------------------------------------------------------------
// pix_tick_gen
// Purpose : divides clk by DIV into a one-clk pixel enable. The divider and
//           the pending tick both freeze while en is low, so pausing never
//           drops or adds a tick and the phase resumes exactly.
// Ports   : clk      in  system clock
//           rst_n    in  synchronous active-low reset
//           en       in  run enable
//           pix_tick out one-clk pulse every DIV clks while en=1
// ----------------------------------------------------------------------------
module pix_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pix_tick
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_q;
  logic [CW-1:0] div_d;
  logic          tick_q;

  assign div_d = (div_q == LAST) ? '0 : div_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      div_q  <= div_d;
      tick_q <= (div_q == LAST);
    end
  end

  // A tick held across a pause is masked until en returns.
  assign pix_tick = tick_q & en;

endmodule

// File: rtl/vga_timing_ctrl.sv
// ----------------------------------------------------------------------------
// vga_timing_ctrl
// Purpose : single-clock VGA raster sequencer. A pixel-tick enable advances
//           the horizontal/vertical counters; phase FSMs track the porch/sync
//           regions, and every level output is registered from next-state
//           values so it lines up with x/y on the same edge.
// Ports   : clk         in   system clock (50 MHz)
//           rst_n       in   synchronous active-low reset
//           en          in   run enable, low freezes the raster
//           pix_tick    out  pixel-rate enable pulse
//           hsync       out  horizontal sync, asserted level = SYNC_POL
//           vsync       out  vertical sync, asserted level = SYNC_POL
//           video_on    out  high inside the visible region
//           x, y        out  current h/v count
//           line_start  out  one-clk pulse after h wraps to 0
//           frame_start out  one-clk pulse after (h,v) wraps to (0,0)
//
// state   | meaning (same encoding for the h and v phase FSMs)
// PH_ACT  | visible pixels / lines
// PH_FP   | front porch
// PH_SYNC | sync pulse asserted
// PH_BP   | back porch
// ----------------------------------------------------------------------------
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned DIV      = DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = SYNC_POL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Every phase must be at least one count wide: the phase FSMs step through
  // each state in order and would stall on a zero-width phase.
  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || DIV < 1 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("vga_timing_ctrl: invalid raster timing parameters");
  end

  localparam logic [CNT_W-1:0] H_LAST       = cnt_c(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST       = cnt_c(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_FP_START   = cnt_c(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = cnt_c(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_BP_START   = cnt_c(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_FP_START   = cnt_c(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_START = cnt_c(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_BP_START   = cnt_c(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  phase_e           h_phase_q, h_phase_d;
  phase_e           v_phase_q, v_phase_d;
  logic             hsync_q, vsync_q, video_on_q;
  logic             line_start_q, frame_start_q;
  logic             h_wrap, f_wrap;

  pix_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .pix_tick(pix_tick)
  );

  always_comb begin
    h_wrap = pix_tick && (h_q == H_LAST);
    f_wrap = h_wrap && (v_q == V_LAST);
    h_d    = h_q;
    v_d    = v_q;
    if (pix_tick) h_d = h_wrap ? '0 : h_q + 1'b1;
    if (h_wrap)   v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
  end

  // Phase transitions look at the next count, so the registered decode lands
  // on the same edge as the counter that caused it.
  always_comb begin
    h_phase_d = h_phase_q;
    case (h_phase_q)
      PH_ACT:  if (h_d == H_FP_START)   h_phase_d = PH_FP;
      PH_FP:   if (h_d == H_SYNC_START) h_phase_d = PH_SYNC;
      PH_SYNC: if (h_d == H_BP_START)   h_phase_d = PH_BP;
      PH_BP:   if (h_d == '0)           h_phase_d = PH_ACT;
      default:                          h_phase_d = PH_ACT;
    endcase
  end

  always_comb begin
    v_phase_d = v_phase_q;
    case (v_phase_q)
      PH_ACT:  if (v_d == V_FP_START)   v_phase_d = PH_FP;
      PH_FP:   if (v_d == V_SYNC_START) v_phase_d = PH_SYNC;
      PH_SYNC: if (v_d == V_BP_START)   v_phase_d = PH_BP;
      PH_BP:   if (v_d == '0)           v_phase_d = PH_ACT;
      default:                          v_phase_d = PH_ACT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      h_phase_q     <= PH_ACT;
      v_phase_q     <= PH_ACT;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      h_phase_q  <= h_phase_d;
      v_phase_q  <= v_phase_d;
      hsync_q    <= (h_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= (v_phase_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_on_q <= (h_phase_d == PH_ACT) && (v_phase_d == PH_ACT);
      // Pulses freeze with the rest of the state during a pause and are
      // masked at the output, so a wrap just before a pause is reported once.
      if (en) begin
        line_start_q  <= h_wrap;
        frame_start_q <= f_wrap;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = h_q;
  assign y           = v_q;
  assign line_start  = line_start_q & en;
  assign frame_start = frame_start_q & en;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en, rst_s_n, en_s;
  logic       pix_tick, hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] x, y;
  logic       pix_tick_s, hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;
  logic [9:0] x_s, y_s;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  // Default 640x480 timing, DIV=2, active-low syncs.
  vga_timing_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  // Tiny raster (13x8, DIV=1, active-high syncs) so whole frames fit the run.
  vga_timing_ctrl #(
    .DIV(1), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_s_n), .en(en_s),
    .pix_tick(pix_tick_s), .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
    .x(x_s), .y(y_s), .line_start(line_start_s), .frame_start(frame_start_s)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    int         n;      // clocks to apply
    int         x;
    int         y;
    logic [5:0] flags;  // {hsync, vsync, video_on, pix_tick, line_start, frame_start}
    int         ticks;  // pix_tick samples during the step, -1 = don't care
    int         lss;    // line_start samples during the step, -1 = don't care
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic e, input int n, input int ex,
                              input int ey, input logic [5:0] f, input int tk, input int lc);
    vec_t v;
    v.rst_n = r; v.en = e; v.n = n; v.x = ex; v.y = ey;
    v.flags = f; v.ticks = tk; v.lss = lc;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int tk, lc, hs_low, fs_cnt, fs_e1, fs_e2, fs_after;
    bit seen;
    logic [25:0] act_v, exp_v;

    rst_n = 1'b0; en = 1'b1; rst_s_n = 1'b0; en_s = 1'b1;

    //            rst   en    n      x    y   hs vs von tk ls fs  ticks lss
    tbl.push_back(mk(1'b0, 1'b1, 5,     0,   0, 6'b110000,    0,  0));
    tbl.push_back(mk(1'b1, 1'b1, 1,     0,   0, 6'b111000,    0,  0));
    tbl.push_back(mk(1'b1, 1'b1, 1,     0,   0, 6'b111100,    1,  0));
    tbl.push_back(mk(1'b1, 1'b1, 1,     1,   0, 6'b111000,    0,  0));
    tbl.push_back(mk(1'b1, 1'b1, 1,     1,   0, 6'b111100,    1,  0));
    tbl.push_back(mk(1'b1, 1'b1, 1275,  639, 0, 6'b111000,  637,  0));
    tbl.push_back(mk(1'b1, 1'b1, 2,     640, 0, 6'b110000,    1,  0));
    tbl.push_back(mk(1'b1, 1'b1, 30,    655, 0, 6'b110000,   15,  0));
    tbl.push_back(mk(1'b1, 1'b1, 2,     656, 0, 6'b010000,    1,  0));
    tbl.push_back(mk(1'b1, 1'b1, 190,   751, 0, 6'b010000,   95,  0));
    tbl.push_back(mk(1'b1, 1'b1, 2,     752, 0, 6'b110000,    1,  0));
    tbl.push_back(mk(1'b1, 1'b1, 94,    799, 0, 6'b110000,   47,  0));
    tbl.push_back(mk(1'b1, 1'b1, 2,     0,   1, 6'b111010,    1,  1));
    tbl.push_back(mk(1'b1, 1'b1, 1,     0,   1, 6'b111100,    1,  0));
    tbl.push_back(mk(1'b1, 1'b1, 14999, 300, 10, 6'b111000, 7499, 9));
    tbl.push_back(mk(1'b1, 1'b0, 37,    300, 10, 6'b111000,   0,  0));
    tbl.push_back(mk(1'b1, 1'b1, 1,     300, 10, 6'b111100,   1,  0));
    tbl.push_back(mk(1'b1, 1'b1, 1,     301, 10, 6'b111000,   0,  0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n;
      en    = tbl[i].en;
      tk = 0; lc = 0;
      repeat (tbl[i].n) begin
        clk1();
        tk += int'(pix_tick);
        lc += int'(line_start);
      end
      chk($sformatf("v%0d.x", i), int'(x), tbl[i].x);
      chk($sformatf("v%0d.y", i), int'(y), tbl[i].y);
      chk($sformatf("v%0d.hsync", i), int'(hsync), int'(tbl[i].flags[5]));
      chk($sformatf("v%0d.vsync", i), int'(vsync), int'(tbl[i].flags[4]));
      chk($sformatf("v%0d.video_on", i), int'(video_on), int'(tbl[i].flags[3]));
      chk($sformatf("v%0d.pix_tick", i), int'(pix_tick), int'(tbl[i].flags[2]));
      chk($sformatf("v%0d.line_start", i), int'(line_start), int'(tbl[i].flags[1]));
      chk($sformatf("v%0d.frame_start", i), int'(frame_start), int'(tbl[i].flags[0]));
      if (tbl[i].ticks >= 0) chk($sformatf("v%0d.tick_count", i), tk, tbl[i].ticks);
      if (tbl[i].lss >= 0) chk($sformatf("v%0d.line_start_count", i), lc, tbl[i].lss);
    end

    // Rest of line 10: hsync low for exactly 96 ticks (192 clks), then one wrap.
    hs_low = 0; seen = 0;
    for (int k = 0; k < 2000 && !seen; k++) begin
      clk1();
      if (hsync == 1'b0) hs_low++;
      if (line_start) seen = 1;
    end
    chk("line_wrap_seen", int'(seen), 1);
    chk("hsync_low_clks", hs_low, 192);
    chk("wrap_x", int'(x), 0);
    chk("wrap_y", int'(y), 11);
    clk1();
    chk("line_start_single", int'(line_start), 0);

    // Small raster: per-clock model over nearly three frames.
    rst_s_n = 1'b1;
    fs_cnt = 0; fs_e1 = 0; fs_e2 = 0;
    for (int e = 1; e <= 300; e++) begin
      int p, ex, ey;
      clk1();
      p  = e - 1;
      ex = p % 13;
      ey = (p / 13) % 8;
      exp_v = {ex[9:0], ey[9:0],
               (ex >= 8 && ex <= 10) ? 1'b1 : 1'b0,
               (ey >= 5 && ey <= 6) ? 1'b1 : 1'b0,
               (ex < 6 && ey < 4) ? 1'b1 : 1'b0,
               1'b1,
               (p > 0 && ex == 0) ? 1'b1 : 1'b0,
               (p > 0 && ex == 0 && ey == 0) ? 1'b1 : 1'b0};
      act_v = {x_s, y_s, hsync_s, vsync_s, video_on_s, pix_tick_s, line_start_s, frame_start_s};
      chk($sformatf("small_clk%0d", e), int'(act_v), int'(exp_v));
      if (frame_start_s) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_e1 = e;
        if (fs_cnt == 2) fs_e2 = e;
      end
    end
    chk("small_frame_starts", fs_cnt, 2);
    chk("small_frame_period", fs_e2 - fs_e1, 104);

    // Mid-frame reset while vsync is asserted on the last sync line.
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      clk1();
      if (y_s == 10'd6) seen = 1;
    end
    chk("small_reach_y6", int'(seen), 1);
    chk("small_pre_rst_vsync", int'(vsync_s), 1);
    rst_s_n = 1'b0;
    clk1();
    chk("small_rst_vsync", int'(vsync_s), 0);
    chk("small_rst_hsync", int'(hsync_s), 0);
    chk("small_rst_x", int'(x_s), 0);
    chk("small_rst_y", int'(y_s), 0);
    chk("small_rst_video_on", int'(video_on_s), 0);
    chk("small_rst_frame_start", int'(frame_start_s), 0);
    chk("small_rst_line_start", int'(line_start_s), 0);
    chk("small_rst_pix_tick", int'(pix_tick_s), 0);
    rst_s_n = 1'b1;
    fs_after = 0;
    repeat (5) begin
      clk1();
      fs_after += int'(frame_start_s) + int'(line_start_s);
    end
    chk("small_post_rst_pulses", fs_after, 0);
    chk("small_post_rst_x", int'(x_s), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
